// File: rtl/reg_file_onehot_pkg.sv
// Shared constants and types for the one-hot-addressed MIPS register file.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_onehot_if.sv
// Write-back / operand-fetch bus of the register file.
// read_valid_in is a strobe with no back-pressure. The request it qualifies is
// answered exactly one cycle later by read_valid_out. There is no ready signal.
interface reg_file_onehot_if;
  import regfile_pkg::*;

  logic                write_enable;
  logic [NUM_REGS-1:0] output_enable;
  reg_word_t           write_data;
  logic                read_valid_in;
  reg_idx_t            read_addr_a;
  reg_idx_t            read_addr_b;
  reg_word_t           read_data_a;
  reg_word_t           read_data_b;
  logic                read_valid_out;
  logic                onehot_err;

  modport master (
    output write_enable, output_enable, write_data,
    output read_valid_in, read_addr_a, read_addr_b,
    input  read_data_a, read_data_b, read_valid_out, onehot_err
  );

  modport slave (
    input  write_enable, output_enable, write_data,
    input  read_valid_in, read_addr_a, read_addr_b,
    output read_data_a, read_data_b, read_valid_out, onehot_err
  );
endinterface

// File: rtl/reg_file_onehot_encoder.sv
// Combinational one-hot to index encoder, the inverse of the write decoder.
// The any output flags one or more set bits. The multi output flags two or more.
module onehot_encoder
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0] onehot,
  output reg_idx_t            idx,
  output logic                any,
  output logic                multi
);

  logic seen;

  // Valid one-hot input: the OR of the set-bit indices is the index.
  // Multi-hot input: idx is meaningless, and multi suppresses its use.
  always_comb begin
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (onehot[i]) begin
        idx   = idx | reg_idx_t'(i);
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    any = seen;
  end

endmodule

// File: rtl/reg_file_onehot.sv
// 32 x DATA_W register file. Writes are addressed by a one-hot enable.
// It has two registered read ports. Define REGFILE_BYPASS_EN to forward a
// same-edge write to the read ports.
module reg_file_onehot
  import regfile_pkg::*;
(
  input logic              clk,
  input logic              rst,
  reg_file_onehot_if.slave bus
);

  reg_word_t regs [NUM_REGS];
  reg_idx_t  wr_idx;
  logic      wr_any;
  logic      wr_multi;
  logic      wr_ok;
  reg_word_t rd_a_next;
  reg_word_t rd_b_next;

  onehot_encoder u_enc (
    .onehot (bus.output_enable),
    .idx    (wr_idx),
    .any    (wr_any),
    .multi  (wr_multi)
  );

  assign wr_ok = bus.write_enable & wr_any & ~wr_multi;

  always_comb begin
    rd_a_next = regs[bus.read_addr_a];
    rd_b_next = regs[bus.read_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && wr_idx == bus.read_addr_a) rd_a_next = bus.write_data;
    if (wr_ok && wr_idx == bus.read_addr_b) rd_b_next = bus.write_data;
`endif
    // Register 0 is hardwired to zero. This also covers a forwarded write to index 0.
    if (bus.read_addr_a == ZERO_REG) rd_a_next = '0;
    if (bus.read_addr_b == ZERO_REG) rd_b_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.read_data_a    <= '0;
      bus.read_data_b    <= '0;
      bus.read_valid_out <= 1'b0;
      bus.onehot_err     <= 1'b0;
    end else begin
      if (wr_ok && wr_idx != ZERO_REG) regs[wr_idx] <= bus.write_data;
      if (bus.read_valid_in) begin
        bus.read_data_a <= rd_a_next;
        bus.read_data_b <= rd_b_next;
      end
      bus.read_valid_out <= bus.read_valid_in;
      if (bus.write_enable && wr_multi) bus.onehot_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_onehot.sv
// Bench for reg_file_onehot: directed scenarios followed by random traffic.
// All of it is checked against an array model of the register file.
module tb_reg_file_onehot;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_onehot_if bus ();

  reg_file_onehot dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state.
  logic [31:0] model [32];
  logic [31:0] exp_a, exp_b;
  logic        exp_v, exp_err;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] oe, input logic [31:0] wd,
                       input logic rv, input logic [4:0] a, input logic [4:0] b);
    bus.write_enable  = we;
    bus.output_enable = oe;
    bus.write_data    = wd;
    bus.read_valid_in = rv;
    bus.read_addr_a   = a;
    bus.read_addr_b   = b;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
  endtask

  // Apply the rules to the inputs present before the edge. Then clock and compare.
  task automatic tick();
    int   hot;
    int   widx;
    logic wr_ok;
    hot   = $countones(bus.output_enable);
    widx  = 0;
    for (int i = 0; i < 32; i++) if (bus.output_enable[i]) widx = i;
    wr_ok = bus.write_enable && (hot == 1);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp_a = 32'h0; exp_b = 32'h0; exp_v = 1'b0; exp_err = 1'b0;
    end else begin
      if (bus.read_valid_in) begin
        exp_a = model[bus.read_addr_a];
        exp_b = model[bus.read_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && widx == int'(bus.read_addr_a) && widx != 0) exp_a = bus.write_data;
        if (wr_ok && widx == int'(bus.read_addr_b) && widx != 0) exp_b = bus.write_data;
`endif
      end
      exp_v = bus.read_valid_in;
      if (bus.write_enable && hot >= 2) exp_err = 1'b1;
      if (wr_ok && widx != 0) model[widx] = bus.write_data;
    end
    @(posedge clk);
    #1;
    chk("read_valid_out", {31'h0, bus.read_valid_out}, {31'h0, exp_v});
    chk("onehot_err", {31'h0, bus.onehot_err}, {31'h0, exp_err});
    chk("read_data_a", bus.read_data_a, exp_a);
    chk("read_data_b", bus.read_data_b, exp_b);
  endtask

  task automatic wr(input int idx, input logic [31:0] wd);
    drive(1'b1, 32'h1 << idx, wd, 1'b0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic rd(input int a, input int b);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 5'(a), 5'(b));
    tick();
  endtask

  initial begin
    logic [31:0] oe;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    idle();
    // Hold reset with a read pending. Outputs must stay cleared.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd9);
    tick(); tick();
    rst = 1'b0;

    // Reset test: load registers, reset during a read request, then read them back.
    wr(5, 32'h5555_5555);
    wr(9, 32'h9999_9999);
    rd(5, 9);
    chk("preload_r5", bus.read_data_a, 32'h5555_5555);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd9);
    tick();
    rst = 1'b0;
    idle();
    tick();
    chk("reset_drops_read", {31'h0, bus.read_valid_out}, 32'h0);
    rd(5, 9);
    chk("reset_r5", bus.read_data_a, 32'h0);
    chk("reset_r9", bus.read_data_b, 32'h0);

    // Basic write followed by a read.
    wr(3, 32'hDEAD_BEEF);
    rd(3, 3);
    chk("wr_rd_r3", bus.read_data_a, 32'hDEAD_BEEF);
    chk("wr_rd_valid", {31'h0, bus.read_valid_out}, 32'h1);
    idle(); tick();

    // Zero register: a write to r0 is discarded, including a same-edge read.
    drive(1'b1, 32'h1, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
    tick();
    chk("zero_same_edge", bus.read_data_a, 32'h0);
    rd(0, 3);
    chk("zero_reg", bus.read_data_a, 32'h0);

    // Multi-hot enable: no write happens, and the error flag becomes sticky.
    wr(4, 32'h11);
    wr(6, 32'h22);
    drive(1'b1, 32'h0000_0050, 32'h99, 1'b0, 5'd0, 5'd0);
    tick();
    chk("multi_err", {31'h0, bus.onehot_err}, 32'h1);
    rd(4, 6);
    chk("multi_r4", bus.read_data_a, 32'h11);
    chk("multi_r6", bus.read_data_b, 32'h22);
    idle(); tick(); tick();
    chk("multi_err_sticky", {31'h0, bus.onehot_err}, 32'h1);
    // Empty enable, and a multi-hot enable with write_enable low, are both ignored.
    drive(1'b1, 32'h0, 32'h77, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b0, 32'h0000_0050, 32'h77, 1'b0, 5'd0, 5'd0); tick();
    rd(4, 6);

    // Same-edge write and read of r7.
    wr(7, 32'h1);
    drive(1'b1, 32'h80, 32'h2, 1'b1, 5'd7, 5'd7);
    tick();
`ifdef REGFILE_BYPASS_EN
    chk("same_edge_r7", bus.read_data_a, 32'h2);
`else
    chk("same_edge_r7", bus.read_data_a, 32'h1);
`endif
    rd(7, 7);
    chk("after_edge_r7", bus.read_data_b, 32'h2);

    // Sweep: write every register, then do back-to-back reads on both ports.
    for (int i = 1; i < 32; i++) wr(i, 32'(i) * 32'h0101);
    for (int i = 0; i < 32; i++) begin
      rd(i, 31 - i);
      chk("sweep_a", bus.read_data_a, 32'(i) * 32'h0101);
      chk("sweep_b", bus.read_data_b, 32'(31 - i) * 32'h0101);
    end

    // Random traffic: one-hot, empty and multi-hot enables, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       oe = 32'h0;
        1:       oe = $urandom() | (32'h1 << $urandom_range(0, 31)) | 32'h3;
        default: oe = 32'h1 << $urandom_range(0, 31);
      endcase
      drive(1'($urandom_range(0, 3) != 0), oe, $urandom(), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
